udp_tx_arb: RTL and testbench
=============================

UDP_TX_ARB -- requirements
Module: udp_tx_arb

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of UDP transmit sources (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning payload AXIS data width (64 or 128).
REQ-003 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, meaning payload byte-enable width.
REQ-004 SHALL have parameter IP_TTL, default 64, meaning constant TTL driven on output.
REQ-005 SHALL have port clk, input, 1, meaning sole clock.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port s_udp_hdr_data, input, CHANNELS*112, meaning per-channel packed header {source_ip[111:80], dest_ip[79:48], source_port[47:32], dest_port[31:16], length[15:0]}.
REQ-008 SHALL have ports s_udp_hdr_valid (input) and s_udp_hdr_ready (output), each CHANNELS bits, meaning per-channel header handshake.
REQ-009 SHALL have ports s_udp_payload_axis_tdata (input, CHANNELS*DATA_WIDTH), _tkeep (input, CHANNELS*KEEP_WIDTH), _tvalid/_tlast/_tuser (input, CHANNELS each) and _tready (output, CHANNELS), meaning per-channel payload stream.
REQ-010 SHALL have ports m_udp_hdr_valid (output, 1), m_udp_hdr_ready (input, 1), m_udp_hdr_data (output, 112) and m_udp_ip_ttl (output, 8), meaning merged header toward udp_complete_64.
REQ-011 SHALL have ports m_udp_payload_axis_tdata/_tkeep/_tvalid/_tlast/_tuser (output) and _tready (input), meaning merged payload stream.
REQ-012 SHALL have port m_udp_tid, output, $clog2(CHANNELS), meaning granted channel index, stable from header through last payload beat.
REQ-013 SHALL have ports length_error (output, 1) and length_error_ch (output, $clog2(CHANNELS)), meaning one-cycle pulse plus offending channel on payload/length mismatch.

Function
REQ-014 SHALL implement FSM states IDLE, HDR, PAYLOAD.
REQ-015 IDLE: when any s_udp_hdr_valid bit is set, SHALL register grant = first requesting channel after last_grant (round-robin, wrap CHANNELS-1 -> 0) and enter HDR next cycle; one cycle arbitration latency.
REQ-016 HDR: m_udp_hdr_valid SHALL equal s_udp_hdr_valid[grant]; m_udp_hdr_data SHALL equal the granted channel's slice; s_udp_hdr_ready[grant] SHALL equal m_udp_hdr_ready combinationally; all other readies 0.
REQ-017 On header handshake SHALL load 16-bit byte counter with length-8 and enter PAYLOAD; length < 8 SHALL load 0 and flag error at frame end.
REQ-018 PAYLOAD: granted channel payload SHALL pass combinationally to m_udp_payload_*; s_udp_payload_axis_tready[grant] = m_udp_payload_axis_tready; non-granted tready 0.
REQ-019 Each payload handshake SHALL subtract popcount(tkeep) from counter, saturating at 0.
REQ-020 On tlast handshake SHALL pulse length_error one cycle later if counter before the beat != popcount(tkeep) of that beat, set last_grant = grant, and return to IDLE.
REQ-021 Frame data and tuser SHALL pass unmodified regardless of length_error.
REQ-022 New header requests arriving during HDR/PAYLOAD SHALL wait; grant SHALL NOT change until tlast handshake.
REQ-023 m_udp_ip_ttl SHALL be constant IP_TTL.
REQ-024 Throughput: back-to-back frames SHALL incur exactly one IDLE cycle between tlast and next header valid.

Reset
REQ-025 On rst SHALL enter IDLE, set last_grant = CHANNELS-1 (channel 0 wins first), clear counter and grant.
REQ-026 During and after reset: m_udp_hdr_valid, m_udp_payload_axis_tvalid, all s_*_ready, length_error SHALL be 0; m_udp_tid 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no tlast emitted; downstream is reset together.

Structure
REQ-028 Header field offsets (112-bit layout), HDR_WIDTH and FSM state encoding SHALL live in shared package udp_stack_pkg.
REQ-029 Round-robin arbiter SHALL be a separate sub-module rr_arbiter (request vector, last grant -> grant index, valid).

Verification
REQ-030 Single channel: ch0 header length=24, two 64-bit beats keep FF/FF -> one header out, tid 0, two beats, length_error 0.
REQ-031 Fairness: all 4 channels request continuously, one-beat frames -> grant order 0,1,2,3,0, one idle cycle between frames.
REQ-032 Mismatch: ch2 length=20, payload 16 bytes -> frame passes intact, length_error pulses 1 cycle after tlast, length_error_ch=2.
REQ-033 Backpressure: m_udp_payload_axis_tready toggling 1/0 during ch1 frame -> no beat lost/duplicated, ch3 request held off until ch1 tlast.
REQ-034 Reset mid-PAYLOAD: rst asserted on beat 2 of 4 -> all valids/readies 0 next cycle; after release ch0 granted first.
REQ-035 Short length: header length=4, one 8-byte beat -> length_error pulses, counter saturates at 0.

Source files
------------

// File: rtl/udp_stack_pkg.sv
// rtl/udp_stack_pkg.sv - shared UDP header layout and transmit arbiter state encoding
package udp_stack_pkg;

    localparam int HDR_WIDTH     = 112;
    localparam int SRC_IP_LSB    = 80;
    localparam int DST_IP_LSB    = 48;
    localparam int SRC_PORT_LSB  = 32;
    localparam int DST_PORT_LSB  = 16;
    localparam int LENGTH_LSB    = 0;
    localparam int UDP_HDR_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } tx_state_t;

    function automatic logic [15:0] hdr_length(input logic [HDR_WIDTH-1:0] hdr);
        return hdr[LENGTH_LSB +: 16];
    endfunction

    function automatic logic [15:0] popcount16(input logic [15:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 16'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requester after the last grant
module rr_arbiter
    import udp_stack_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/udp_tx_arb.sv
// rtl/udp_tx_arb.sv - merges per-channel UDP header+payload sources into one frame stream
module udp_tx_arb
    import udp_stack_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int IP_TTL     = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNELS*HDR_WIDTH-1:0]     s_udp_hdr_data,
    input  logic [CHANNELS-1:0]               s_udp_hdr_valid,
    output logic [CHANNELS-1:0]               s_udp_hdr_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    s_udp_payload_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0]    s_udp_payload_axis_tkeep,
    input  logic [CHANNELS-1:0]               s_udp_payload_axis_tvalid,
    input  logic [CHANNELS-1:0]               s_udp_payload_axis_tlast,
    input  logic [CHANNELS-1:0]               s_udp_payload_axis_tuser,
    output logic [CHANNELS-1:0]               s_udp_payload_axis_tready,
    output logic                              m_udp_hdr_valid,
    input  logic                              m_udp_hdr_ready,
    output logic [HDR_WIDTH-1:0]              m_udp_hdr_data,
    output logic [7:0]                        m_udp_ip_ttl,
    output logic [DATA_WIDTH-1:0]             m_udp_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]             m_udp_payload_axis_tkeep,
    output logic                              m_udp_payload_axis_tvalid,
    output logic                              m_udp_payload_axis_tlast,
    output logic                              m_udp_payload_axis_tuser,
    input  logic                              m_udp_payload_axis_tready,
    output logic [$clog2(CHANNELS)-1:0]       m_udp_tid,
    output logic                              length_error,
    output logic [$clog2(CHANNELS)-1:0]       length_error_ch
);

    localparam int IDX_W = $clog2(CHANNELS);

    tx_state_t        state, state_next;
    logic [IDX_W-1:0] grant, grant_next;
    logic [IDX_W-1:0] last_grant, last_grant_next;
    logic [IDX_W-1:0] arb_grant, lerr_ch_next;
    logic             arb_valid, short_len, short_len_next, lerr_next;
    logic             hdr_fire, pay_fire;
    logic [15:0]      byte_cnt, byte_cnt_next, beat_bytes, hdr_len;

    rr_arbiter #(.N(CHANNELS), .IDX_W(IDX_W)) u_arb (
        .req        (s_udp_hdr_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Data paths follow the grant unconditionally; only valids and readies are gated.
    always_comb begin
        s_udp_hdr_ready           = '0;
        s_udp_payload_axis_tready = '0;
        m_udp_hdr_valid           = 1'b0;
        m_udp_payload_axis_tvalid = 1'b0;
        m_udp_hdr_data            = s_udp_hdr_data[int'(grant)*HDR_WIDTH +: HDR_WIDTH];
        m_udp_payload_axis_tdata  = s_udp_payload_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        m_udp_payload_axis_tkeep  = s_udp_payload_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
        m_udp_payload_axis_tlast  = s_udp_payload_axis_tlast[grant];
        m_udp_payload_axis_tuser  = s_udp_payload_axis_tuser[grant];
        if (!rst && state == ST_HDR) begin
            m_udp_hdr_valid        = s_udp_hdr_valid[grant];
            s_udp_hdr_ready[grant] = m_udp_hdr_ready;
        end
        if (!rst && state == ST_PAYLOAD) begin
            m_udp_payload_axis_tvalid        = s_udp_payload_axis_tvalid[grant];
            s_udp_payload_axis_tready[grant] = m_udp_payload_axis_tready;
        end
    end

    assign m_udp_ip_ttl = 8'(IP_TTL);
    assign m_udp_tid    = grant;
    assign hdr_fire     = m_udp_hdr_valid && m_udp_hdr_ready;
    assign pay_fire     = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready;
    assign beat_bytes   = popcount16(16'(m_udp_payload_axis_tkeep));
    assign hdr_len      = hdr_length(m_udp_hdr_data);

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        byte_cnt_next   = byte_cnt;
        short_len_next  = short_len;
        lerr_next       = 1'b0;
        lerr_ch_next    = length_error_ch;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_next = arb_grant;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_fire) begin
                    // A length shorter than the UDP header can never be met; remember it for frame end.
                    short_len_next = hdr_len < 16'(UDP_HDR_BYTES);
                    byte_cnt_next  = short_len_next ? 16'd0 : hdr_len - 16'(UDP_HDR_BYTES);
                    state_next     = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (pay_fire) begin
                    byte_cnt_next = (byte_cnt > beat_bytes) ? byte_cnt - beat_bytes : 16'd0;
                    if (m_udp_payload_axis_tlast) begin
                        lerr_next       = short_len || (byte_cnt != beat_bytes);
                        lerr_ch_next    = grant;
                        last_grant_next = grant;
                        state_next      = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            grant           <= '0;
            last_grant      <= IDX_W'(CHANNELS - 1);
            byte_cnt        <= '0;
            short_len       <= 1'b0;
            length_error    <= 1'b0;
            length_error_ch <= '0;
        end else begin
            state           <= state_next;
            grant           <= grant_next;
            last_grant      <= last_grant_next;
            byte_cnt        <= byte_cnt_next;
            short_len       <= short_len_next;
            length_error    <= lerr_next;
            length_error_ch <= lerr_ch_next;
        end
    end

endmodule

// File: tb/tb_udp_tx_arb.sv
// tb/tb_udp_tx_arb.sv - scoreboard bench for the UDP transmit arbiter
module tb_udp_tx_arb;
    import udp_stack_pkg::*;

    localparam int CH = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [CH*HDR_WIDTH-1:0] s_udp_hdr_data;
    logic [CH-1:0]         s_udp_hdr_valid, s_udp_hdr_ready;
    logic [CH*DW-1:0]      s_udp_payload_axis_tdata;
    logic [CH*KW-1:0]      s_udp_payload_axis_tkeep;
    logic [CH-1:0]         s_udp_payload_axis_tvalid, s_udp_payload_axis_tlast;
    logic [CH-1:0]         s_udp_payload_axis_tuser, s_udp_payload_axis_tready;
    logic                  m_udp_hdr_valid, m_udp_hdr_ready;
    logic [HDR_WIDTH-1:0]  m_udp_hdr_data;
    logic [7:0]            m_udp_ip_ttl;
    logic [DW-1:0]         m_udp_payload_axis_tdata;
    logic [KW-1:0]         m_udp_payload_axis_tkeep;
    logic                  m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast;
    logic                  m_udp_payload_axis_tuser, m_udp_payload_axis_tready;
    logic [1:0]            m_udp_tid, length_error_ch;
    logic                  length_error;

    always #5 clk = ~clk;

    udp_tx_arb #(.CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IP_TTL(64)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_udp_hdr_data            (s_udp_hdr_data),
        .s_udp_hdr_valid           (s_udp_hdr_valid),
        .s_udp_hdr_ready           (s_udp_hdr_ready),
        .s_udp_payload_axis_tdata  (s_udp_payload_axis_tdata),
        .s_udp_payload_axis_tkeep  (s_udp_payload_axis_tkeep),
        .s_udp_payload_axis_tvalid (s_udp_payload_axis_tvalid),
        .s_udp_payload_axis_tlast  (s_udp_payload_axis_tlast),
        .s_udp_payload_axis_tuser  (s_udp_payload_axis_tuser),
        .s_udp_payload_axis_tready (s_udp_payload_axis_tready),
        .m_udp_hdr_valid           (m_udp_hdr_valid),
        .m_udp_hdr_ready           (m_udp_hdr_ready),
        .m_udp_hdr_data            (m_udp_hdr_data),
        .m_udp_ip_ttl              (m_udp_ip_ttl),
        .m_udp_payload_axis_tdata  (m_udp_payload_axis_tdata),
        .m_udp_payload_axis_tkeep  (m_udp_payload_axis_tkeep),
        .m_udp_payload_axis_tvalid (m_udp_payload_axis_tvalid),
        .m_udp_payload_axis_tlast  (m_udp_payload_axis_tlast),
        .m_udp_payload_axis_tuser  (m_udp_payload_axis_tuser),
        .m_udp_payload_axis_tready (m_udp_payload_axis_tready),
        .m_udp_tid                 (m_udp_tid),
        .length_error              (length_error),
        .length_error_ch           (length_error_ch)
    );

    logic [HDR_WIDTH-1:0] src_hdr_q  [CH][$];
    beat_t                src_beat_q [CH][$];
    logic [127:0]         exp_q [$];
    logic [2:0]           err_q [$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, beat_cnt = 0, last_tlast = -1;
    logic gap_chk = 1'b0, bp = 1'b0, pend_v = 1'b0;
    logic [2:0] pend = '0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [HDR_WIDTH-1:0] make_hdr(input int ch, input int tag, input int len);
        logic [HDR_WIDTH-1:0] h;
        h = '0;
        h[SRC_IP_LSB +: 32]   = 32'hC0A8_0000 | 32'(ch);
        h[DST_IP_LSB +: 32]   = 32'h0A00_0000 | 32'(tag);
        h[SRC_PORT_LSB +: 16] = 16'(1000 + ch);
        h[DST_PORT_LSB +: 16] = 16'(2000 + tag);
        h[LENGTH_LSB +: 16]   = 16'(len);
        return h;
    endfunction

    function automatic beat_t make_beat(input int ch, input int tag, input int b, input int n,
                                        input logic [7:0] lk);
        beat_t x;
        x.data = {8'(ch), 8'(tag), 16'(b), 32'(ch * 16 + b) ^ 32'hDEAD_BEEF};
        x.keep = (b == n - 1) ? lk : 8'hFF;
        x.last = (b == n - 1);
        x.user = (b == n - 1) && tag[0];
        return x;
    endfunction

    function automatic int pc8(input logic [7:0] k);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(k[i]);
        return n;
    endfunction

    task automatic src_frame(input int ch, input int tag, input int len, input int n, input logic [7:0] lk);
        src_hdr_q[ch].push_back(make_hdr(ch, tag, len));
        for (int b = 0; b < n; b++) src_beat_q[ch].push_back(make_beat(ch, tag, b, n, lk));
    endtask

    // Expected output: header, beats, then the length check verdict for this frame.
    task automatic exp_frame(input int ch, input int tag, input int len, input int n, input logic [7:0] lk);
        int   cnt;
        logic err;
        exp_q.push_back({13'd0, 1'b0, 2'(ch), make_hdr(ch, tag, len)});
        for (int b = 0; b < n; b++) exp_q.push_back({51'd0, 1'b1, 2'(ch), make_beat(ch, tag, b, n, lk)});
        cnt = (len < 8) ? 0 : len - 8;
        for (int b = 0; b < n - 1; b++) cnt = (cnt > 8) ? cnt - 8 : 0;
        err = (len < 8) || (cnt != pc8(lk));
        err_q.push_back({err, 2'(ch)});
    endtask

    task automatic run_frame(input int ch, input int tag, input int len, input int n, input logic [7:0] lk);
        src_frame(ch, tag, len, n, lk);
        exp_frame(ch, tag, len, n, lk);
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0 || pend_v) && t < max_cyc) begin
            @(posedge clk); #1;
            if (bp) m_udp_payload_axis_tready = ~m_udp_payload_axis_tready;
            t++;
        end
        check_eq({tag, ".drained"}, 128'(exp_q.size() + err_q.size() + int'(pend_v)), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".m_hdr_valid"}, m_udp_hdr_valid, 0);
        check_eq({tag, ".m_tvalid"}, m_udp_payload_axis_tvalid, 0);
        check_eq({tag, ".s_hdr_ready"}, s_udp_hdr_ready, 0);
        check_eq({tag, ".s_tready"}, s_udp_payload_axis_tready, 0);
        check_eq({tag, ".length_error"}, length_error, 0);
        check_eq({tag, ".tid"}, m_udp_tid, 0);
        check_eq({tag, ".ttl"}, m_udp_ip_ttl, 64);
    endtask

    // Per-channel sources: present queue heads at negedge, note handshakes just before posedge.
    for (genvar c = 0; c < CH; c++) begin : g_src
        logic                 hv, pv, hf, pf;
        logic [HDR_WIDTH-1:0] hd;
        beat_t                pb;
        assign s_udp_hdr_valid[c]                    = hv;
        assign s_udp_hdr_data[c*HDR_WIDTH +: HDR_WIDTH] = hd;
        assign s_udp_payload_axis_tvalid[c]          = pv;
        assign s_udp_payload_axis_tdata[c*DW +: DW]  = pb.data;
        assign s_udp_payload_axis_tkeep[c*KW +: KW]  = pb.keep;
        assign s_udp_payload_axis_tlast[c]           = pb.last;
        assign s_udp_payload_axis_tuser[c]           = pb.user;
        initial begin
            hv = 1'b0; pv = 1'b0; hf = 1'b0; pf = 1'b0; hd = '0; pb = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    src_hdr_q[c].delete();
                    src_beat_q[c].delete();
                    hf = 1'b0;
                    pf = 1'b0;
                end
                if (hf) void'(src_hdr_q[c].pop_front());
                if (pf) void'(src_beat_q[c].pop_front());
                hv = src_hdr_q[c].size() > 0;
                hd = hv ? src_hdr_q[c][0] : '0;
                pv = src_beat_q[c].size() > 0;
                pb = pv ? src_beat_q[c][0] : '0;
                #1;
                hf = hv && s_udp_hdr_ready[c];
                pf = pv && s_udp_payload_axis_tready[c];
            end
        end
    end

    initial begin : monitor
        logic [127:0] e;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (rst) begin
                pend_v = 1'b0;
            end else begin
                if (pend_v) begin
                    check_eq("length_error", length_error, pend[2]);
                    if (pend[2]) check_eq("length_error_ch", length_error_ch, pend[1:0]);
                    pend_v = 1'b0;
                end else if (length_error) begin
                    check_eq("length_error_spurious", length_error, 0);
                end
                if (m_udp_hdr_valid && m_udp_hdr_ready) begin
                    if (exp_q.size() == 0) check_eq("hdr_unexpected", m_udp_hdr_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        check_eq("hdr", {13'd0, 1'b0, m_udp_tid, m_udp_hdr_data}, e);
                    end
                    if (gap_chk && last_tlast >= 0) check_eq("idle_gap", 128'(cyc - last_tlast), 2);
                end
                if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready) begin
                    beat_cnt++;
                    if (exp_q.size() == 0) check_eq("beat_unexpected", m_udp_payload_axis_tvalid, 0);
                    else begin
                        e = exp_q.pop_front();
                        check_eq("beat", {51'd0, 1'b1, m_udp_tid, m_udp_payload_axis_tdata,
                                          m_udp_payload_axis_tkeep, m_udp_payload_axis_tlast,
                                          m_udp_payload_axis_tuser}, e);
                    end
                    if (m_udp_payload_axis_tlast) begin
                        last_tlast = cyc;
                        if (err_q.size() > 0) begin
                            pend   = err_q.pop_front();
                            pend_v = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1;
        m_udp_hdr_ready = 1'b1;
        m_udp_payload_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        gap_chk = 1'b1;
        for (int c = 0; c < CH; c++) src_frame(c, 1, 16, 1, 8'hFF);
        src_frame(0, 2, 16, 1, 8'hFF);
        for (int c = 0; c < CH; c++) exp_frame(c, 1, 16, 1, 8'hFF);
        exp_frame(0, 2, 16, 1, 8'hFF);
        wait_drain("fairness", 200);
        gap_chk = 1'b0;

        run_frame(0, 3, 24, 2, 8'hFF);
        wait_drain("single", 100);

        run_frame(2, 4, 20, 2, 8'hFF);
        wait_drain("mismatch", 100);

        run_frame(1, 5, 48, 5, 8'hFF);
        bp = 1'b1;
        t = 0;
        while (exp_q.size() > 5 && t < 50) begin
            @(posedge clk); #1;
            m_udp_payload_axis_tready = ~m_udp_payload_axis_tready;
            t++;
        end
        run_frame(3, 6, 16, 1, 8'hFF);
        wait_drain("backpressure", 200);
        bp = 1'b0;
        m_udp_payload_axis_tready = 1'b1;

        run_frame(0, 7, 4, 1, 8'hFF);
        wait_drain("short", 100);

        run_frame(1, 8, 20, 2, 8'h0F);
        wait_drain("partial", 100);

        beat_cnt = 0;
        run_frame(1, 9, 40, 4, 8'hFF);
        t = 0;
        while (beat_cnt < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("rst_mid.beats_before", 128'(beat_cnt), 2);
        rst = 1'b1;
        exp_q.delete();
        err_q.delete();
        @(posedge clk); #1;
        check_reset("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        src_frame(2, 10, 16, 1, 8'hFF);
        src_frame(0, 11, 16, 1, 8'hFF);
        exp_frame(0, 11, 16, 1, 8'hFF);
        exp_frame(2, 10, 16, 1, 8'hFF);
        wait_drain("after_reset", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
